// File: rtl/jtag_tap_pkg.sv
// jtag_tap_pkg: TAP state encoding, opcodes and DR selection shared by the TAP controller.
package jtag_tap_pkg;
  localparam int IR_LEN = 4;
  localparam logic [31:0] IDCODE_VALUE = 32'h149511C3;
  localparam logic [IR_LEN-1:0] OPC_IDCODE = 4'b0010;
  localparam logic [IR_LEN-1:0] OPC_DEBUG = 4'b1000;
  localparam logic [IR_LEN-1:0] OPC_BYPASS = 4'b1111;
  localparam logic [IR_LEN-1:0] IR_CAPTURE = 4'b0101;
  typedef enum logic [3:0] {
    EX2_DR   = 4'h0,
    EX1_DR   = 4'h1,
    SH_DR    = 4'h2,
    PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4,
    UPD_DR   = 4'h5,
    CAP_DR   = 4'h6,
    SEL_DR   = 4'h7,
    EX2_IR   = 4'h8,
    EX1_IR   = 4'h9,
    SH_IR    = 4'hA,
    PAUSE_IR = 4'hB,
    RTI      = 4'hC,
    UPD_IR   = 4'hD,
    CAP_IR   = 4'hE,
    TLR      = 4'hF
  } tap_state_e;
  typedef enum logic [1:0] {DR_BYPASS, DR_IDCODE, DR_DEBUG} dr_sel_e;
  // Anything that is not IDCODE or DEBUG falls back to BYPASS, including OPC_BYPASS itself.
  function automatic dr_sel_e decode_ir(input logic [IR_LEN-1:0] ir);
    return ir == OPC_IDCODE ? DR_IDCODE : ir == OPC_DEBUG ? DR_DEBUG : DR_BYPASS;
  endfunction
endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: 16-state 1149.1 TAP state machine with combinational state decodes.
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic tck,
  input  logic trst_n,
  input  logic tms,
  output logic test_logic_reset,
  output logic run_test_idle,
  output logic capture_dr,
  output logic shift_dr,
  output logic pause_dr,
  output logic update_dr,
  output logic capture_ir,
  output logic shift_ir,
  output logic update_ir
);
  tap_state_e state, state_nxt;
  always_ff @(posedge tck or negedge trst_n)
    if (!trst_n) state <= TLR;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      TLR:      state_nxt = tms ? TLR : RTI;
      RTI:      state_nxt = tms ? SEL_DR : RTI;
      SEL_DR:   state_nxt = tms ? SEL_IR : CAP_DR;
      CAP_DR:   state_nxt = tms ? EX1_DR : SH_DR;
      SH_DR:    state_nxt = tms ? EX1_DR : SH_DR;
      EX1_DR:   state_nxt = tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR: state_nxt = tms ? EX2_DR : PAUSE_DR;
      EX2_DR:   state_nxt = tms ? UPD_DR : SH_DR;
      UPD_DR:   state_nxt = tms ? SEL_DR : RTI;
      SEL_IR:   state_nxt = tms ? TLR : CAP_IR;
      CAP_IR:   state_nxt = tms ? EX1_IR : SH_IR;
      SH_IR:    state_nxt = tms ? EX1_IR : SH_IR;
      EX1_IR:   state_nxt = tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR: state_nxt = tms ? EX2_IR : PAUSE_IR;
      EX2_IR:   state_nxt = tms ? UPD_IR : SH_IR;
      UPD_IR:   state_nxt = tms ? SEL_DR : RTI;
      default:  state_nxt = TLR;
    endcase
  end
  assign test_logic_reset = state == TLR;
  assign run_test_idle    = state == RTI;
  assign capture_dr       = state == CAP_DR;
  assign shift_dr         = state == SH_DR;
  assign pause_dr         = state == PAUSE_DR;
  assign update_dr        = state == UPD_DR;
  assign capture_ir       = state == CAP_IR;
  assign shift_ir         = state == SH_IR;
  assign update_ir        = state == UPD_IR;
endmodule

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: IEEE 1149.1 TAP with 4-bit IR, IDCODE/BYPASS DRs and a pass-through DEBUG DR port.
module jtag_tap_ctrl
  import jtag_tap_pkg::*;
(
  input  logic tck,
  input  logic trst_n,
  input  logic tms,
  input  logic tdi,
  output logic tdo,
  output logic tdo_oe,
  output logic test_logic_reset,
  output logic run_test_idle,
  output logic capture_dr,
  output logic shift_dr,
  output logic pause_dr,
  output logic update_dr,
  output logic debug_select,
  output logic debug_tdi,
  input  logic debug_tdo
);
  logic capture_ir, shift_ir, update_ir;
  logic [IR_LEN-1:0] ir, ir_sr;
  logic [31:0] id_sr;
  logic bp_sr, dr_tdo;
  dr_sel_e dr_sel;
  jtag_tap_fsm u_fsm (
    .tck(tck),
    .trst_n(trst_n),
    .tms(tms),
    .test_logic_reset(test_logic_reset),
    .run_test_idle(run_test_idle),
    .capture_dr(capture_dr),
    .shift_dr(shift_dr),
    .pause_dr(pause_dr),
    .update_dr(update_dr),
    .capture_ir(capture_ir),
    .shift_ir(shift_ir),
    .update_ir(update_ir)
  );
  assign dr_sel = decode_ir(ir);
  assign debug_select = dr_sel == DR_DEBUG;
  assign debug_tdi = tdi;
  assign dr_tdo = dr_sel == DR_IDCODE ? id_sr[0] : dr_sel == DR_DEBUG ? debug_tdo : bp_sr;
  always_ff @(posedge tck or negedge trst_n)
    if (!trst_n) begin
      ir_sr <= '0;
      id_sr <= '0;
      bp_sr <= 1'b0;
    end else begin
      ir_sr <= capture_ir ? IR_CAPTURE : shift_ir ? {tdi, ir_sr[IR_LEN-1:1]} : ir_sr;
      id_sr <= dr_sel != DR_IDCODE ? id_sr : capture_dr ? IDCODE_VALUE : shift_dr ? {tdi, id_sr[31:1]} : id_sr;
      bp_sr <= dr_sel != DR_BYPASS ? bp_sr : capture_dr ? 1'b0 : shift_dr ? tdi : bp_sr;
    end
  // Falling-edge side: the active IR changes here so the new instruction is stable by the next rise.
  always_ff @(negedge tck or negedge trst_n)
    if (!trst_n) begin
      ir     <= OPC_IDCODE;
      tdo    <= 1'b0;
      tdo_oe <= 1'b0;
    end else begin
      ir     <= test_logic_reset ? OPC_IDCODE : update_ir ? ir_sr : ir;
      tdo    <= shift_ir ? ir_sr[0] : shift_dr ? dr_tdo : 1'b0;
      tdo_oe <= shift_ir | shift_dr;
    end
endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb_jtag_tap_ctrl: directed TAP scans; expected tdo bits are queued by stimulus and checked by a monitor.
module tb_jtag_tap_ctrl;
  logic tck = 1'b0, trst_n = 1'b0, tms = 1'b1, tdi = 1'b0, debug_tdo = 1'b0;
  logic tdo, tdo_oe, test_logic_reset, run_test_idle, capture_dr, shift_dr, pause_dr, update_dr;
  logic debug_select, debug_tdi;
  int checks = 0, passes = 0;
  logic q[$];
  logic [31:0] id = 32'h149511C3;
  logic [7:0] a5 = 8'hA5, pv = 8'h6C;
  jtag_tap_ctrl dut (
    .tck(tck),
    .trst_n(trst_n),
    .tms(tms),
    .tdi(tdi),
    .tdo(tdo),
    .tdo_oe(tdo_oe),
    .test_logic_reset(test_logic_reset),
    .run_test_idle(run_test_idle),
    .capture_dr(capture_dr),
    .shift_dr(shift_dr),
    .pause_dr(pause_dr),
    .update_dr(update_dr),
    .debug_select(debug_select),
    .debug_tdi(debug_tdi),
    .debug_tdo(debug_tdo)
  );
  always #5 tck = ~tck;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  task automatic step(input logic t, input logic d);
    tms = t;
    tdi = d;
    @(posedge tck);
    #1;
  endtask
  task automatic ir_scan(input logic [3:0] v);
    q.push_back(1'b1); q.push_back(1'b0); q.push_back(1'b1); q.push_back(1'b0);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 4; i++) step(i == 3, v[i]);
    step(1, 0);
    step(0, 0);
    chk("ir_loaded", 32'(dut.ir), 32'(v));
  endtask
  task automatic dr_scan(input logic [31:0] d, input logic [31:0] dbg, input int n);
    step(1, 0);
    step(0, 0);
    chk("capture_dr", 32'(capture_dr), 32'd1);
    step(0, 0);
    for (int i = 0; i < n; i++) begin
      debug_tdo = dbg[i];
      step(i == n - 1, d[i]);
    end
    step(1, 0);
    chk("update_dr", 32'(update_dr), 32'd1);
    step(0, 0);
    chk("back_to_rti", 32'(run_test_idle), 32'd1);
  endtask
  always @(negedge tck) begin
    #2;
    if (tdo_oe) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL tdo_unexpected: got tdo_oe=1 tdo=%b expected no shift output at %0t", tdo, $time);
      end else chk("tdo", 32'(tdo), 32'(q.pop_front()));
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    @(posedge tck);
    #1;
    chk("rst_tlr", 32'(test_logic_reset), 32'd1);
    chk("rst_rti", 32'(run_test_idle), 32'd0);
    chk("rst_tdo", 32'(tdo), 32'd0);
    chk("rst_tdo_oe", 32'(tdo_oe), 32'd0);
    chk("rst_debug_select", 32'(debug_select), 32'd0);
    trst_n = 1'b1;
    step(0, 0);
    chk("enter_rti", 32'(run_test_idle), 32'd1);
    for (int i = 0; i < 32; i++) q.push_back(id[i]);
    dr_scan(32'h0, 32'h0, 32);
    ir_scan(4'b1111);
    q.push_back(1'b0);
    for (int i = 0; i < 7; i++) q.push_back(a5[i]);
    dr_scan(32'(a5), 32'h0, 8);
    ir_scan(4'b1000);
    chk("debug_select_on", 32'(debug_select), 32'd1);
    tdi = 1'b1; #1 chk("debug_tdi_hi", 32'(debug_tdi), 32'd1);
    tdi = 1'b0; #1 chk("debug_tdi_lo", 32'(debug_tdi), 32'd0);
    q.push_back(1'b1); q.push_back(1'b0); q.push_back(1'b1);
    dr_scan(32'h0, 32'h5, 3);
    ir_scan(4'b0110);
    chk("debug_select_off", 32'(debug_select), 32'd0);
    q.push_back(1'b0);
    for (int i = 0; i < 7; i++) q.push_back(pv[i]);
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 4; i++) step(i == 3, pv[i]);
    step(0, 0);
    chk("pause_enter", 32'(pause_dr), 32'd1);
    step(0, 0); step(0, 0);
    chk("pause_hold", 32'(pause_dr), 32'd1);
    step(1, 0); step(0, 0);
    chk("shift_resume", 32'(shift_dr), 32'd1);
    for (int i = 4; i < 8; i++) step(i == 7, pv[i]);
    step(1, 0); step(0, 0);
    q.push_back(1'b0); q.push_back(1'b1);
    step(1, 0); step(0, 0); step(0, 0);
    step(0, 1); step(0, 1);
    #2 trst_n = 1'b0;
    #1;
    chk("trst_tlr", 32'(test_logic_reset), 32'd1);
    chk("trst_shift_dr", 32'(shift_dr), 32'd0);
    chk("trst_tdo", 32'(tdo), 32'd0);
    chk("trst_tdo_oe", 32'(tdo_oe), 32'd0);
    chk("trst_ir", 32'(dut.ir), 32'h2);
    @(posedge tck);
    #1 trst_n = 1'b1;
    step(0, 0);
    chk("rti_after_trst", 32'(run_test_idle), 32'd1);
    ir_scan(4'b1111);
    step(1, 0); step(1, 0);
    chk("not_tlr_yet", 32'(test_logic_reset), 32'd0);
    step(1, 0); step(1, 0); step(1, 0);
    chk("tms5_tlr", 32'(test_logic_reset), 32'd1);
    #5;
    chk("tlr_ir_reset", 32'(dut.ir), 32'h2);
    step(1, 0); step(1, 0);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/jtag_tap_ctrl.md
# jtag_tap_ctrl

Synthesizable IEEE 1149.1 TAP controller that sits directly downstream of the simulation JTAG driver. It consumes tck/tms/tdi and returns tdo, exposing the 16-state TAP FSM, a 4-bit instruction register, IDCODE and BYPASS data registers, and a DEBUG data-register port for the debug unit behind it. The driver's reset (5×TMS=1), RunTestIdle entry and TMS-flip-on-last-bit scans must all work against this block unmodified.

## Interface
- IR_LEN, 4, instruction register width
- IDCODE_VALUE, 32'h149511C3, value captured by IDCODE (bit 0 must be 1)
- OPC_IDCODE, 4'b0010, IDCODE opcode
- OPC_DEBUG, 4'b1000, DEBUG opcode
- OPC_BYPASS, 4'b1111, BYPASS opcode
- tck  in  1  TAP clock; only clock in the block
- trst_n  in  1  asynchronous, active-low reset
- tms  in  1  test mode select, sampled on tck rise
- tdi  in  1  test data in, sampled on tck rise
- tdo  out  1  test data out, changes on tck fall
- tdo_oe  out  1  high while in SHIFT_IR or SHIFT_DR
- test_logic_reset  out  1  FSM in TEST_LOGIC_RESET
- run_test_idle  out  1  FSM in RUN_TEST_IDLE
- capture_dr / shift_dr / pause_dr / update_dr  out  1 each  FSM state decodes
- debug_select  out  1  IR holds OPC_DEBUG
- debug_tdi  out  1  tdi passed to debug unit
- debug_tdo  in  1  serial return from debug unit

## Operation
- FSM: standard 16 states (TLR, RTI, SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR, and the IR mirror set); transitions per 1149.1 on tms at tck rise.
- Five consecutive tms=1 rises reach TLR from any state.
- IR: CAPTURE_IR loads 4'b0101; SHIFT_IR shifts right, tdi into MSB; UPDATE_IR copies shift reg to active IR.
- Active IR resets to OPC_IDCODE in TLR and on trst_n.
- Unknown opcodes select BYPASS.
- IDCODE DR: 32-bit; CAPTURE_DR loads IDCODE_VALUE; SHIFT_DR shifts right, tdi into bit 31.
- BYPASS DR: 1-bit; CAPTURE_DR loads 0; SHIFT_DR loads tdi.
- DEBUG: debug_select=1; debug_tdi=tdi always; tdo source is debug_tdo; block keeps no DR of its own.
- tdo mux: SHIFT_IR → IR shift LSB; SHIFT_DR → selected DR LSB/debug_tdo; else 0.
- tdo_oe tracks the same states.

## Timing
- State, IR shift and DR shifts update on tck rise.
- Active IR updates on tck fall while in UPDATE_IR, so the new instruction is visible from the following rise.
- tdo and tdo_oe are registered on tck fall, half a period after the shift edge. The first shifted bit appears on the fall after the CAPTURE→SHIFT rise.
- State decode outputs are combinational from the state register.
- trst_n low, async: state=TLR, IR=OPC_IDCODE, IR shift=0, DR shifts=0, tdo=0, tdo_oe=0, debug_select=0, test_logic_reset=1, others 0.
- Release is synchronous to the next tck rise.
- trst_n asserted mid-shift aborts immediately; no UPDATE occurs.
- EXIT1→UPDATE without further shifting still updates with current shift contents.
- PAUSE_* holds the shift registers unchanged.

## Structure
- Package jtag_tap_pkg: 4-bit state enum/localparams, default opcodes, IR_CAPTURE=4'b0101.
- Sub-module jtag_tap_fsm: state register plus next-state logic and state decodes. The top level holds IR, DRs and the tdo mux.

## Test plan
- trst_n pulse mid-SHIFT_DR → state TLR, tdo=0, tdo_oe=0, IR=0010 at once.
- From RTI, tms=1,1,1,1,1 → test_logic_reset=1 after 5th rise.
- Reset → RTI, tms 1,0,0 to SHIFT_DR, shift 32 bits with tdi=0 → tdo stream LSB-first equals 0x149511C3.
- IR scan shifting in 4'b1111 → first 4 tdo bits 1,0,1,0. Then DR-shift 8'hA5 with TMS flip on last bit → tdo shows 0 then bits of A5 delayed one cycle.
- IR=4'b1000 → debug_select=1. debug_tdo toggled 1,0,1 during SHIFT_DR appears on tdo each tck fall; debug_tdi mirrors tdi.
- IR=4'b0110 (unknown) → BYPASS behaviour; PAUSE_DR for 3 cycles then resume → no bits lost or duplicated.
